approx_mul_pipe: RTL

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

---
 rtl/approx_mul_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined nibble-array multiplier with optional approximate mode
// that drops the lowest TRUNC partial-product diagonals. Define APPROX_MUL_ERRCNT_EN for err_cnt.
module approx_mul_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TRUNC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               approx,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               prod_approx,
   output logic               out_valid,
   input  logic               out_ready
`ifdef APPROX_MUL_ERRCNT_EN
   ,
   output logic [15:0]        err_cnt
`endif
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned ND = 2 * N - 1;
   localparam int unsigned DW = 9 + $clog2(N);
   localparam int unsigned PW = 2 * WIDTH;

   logic [7:0]    pp_n [N][N];
   logic [7:0]    pp1  [N][N];
   logic          ap1, v1;
   logic [DW-1:0] ds_n [ND];
   logic [DW-1:0] ds2  [ND];
   logic          ap2, v2;
   logic [PW-1:0] ex_n, apx_n;
   logic          en;

   // Whole pipeline advances together; only a blocked output can stall it.
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            pp_n[i][j] = 8'(a[4*i +: 4]) * 8'(b[4*j +: 4]);
         end
      end
   end

   always_comb begin
      for (int unsigned d = 0; d < ND; d++) begin
         ds_n[d] = '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            ds_n[i+j] = ds_n[i+j] + DW'(pp1[i][j]);
         end
      end
   end

   // Exact and truncated sums are both formed from the diagonal sums at S3 load.
   always_comb begin
      ex_n  = '0;
      apx_n = '0;
      for (int unsigned d = 0; d < ND; d++) begin
         ex_n = ex_n + (PW'(ds2[d]) << (4 * d));
         if (d >= TRUNC) begin
            apx_n = apx_n + (PW'(ds2[d]) << (4 * d));
         end
      end
   end

`ifdef APPROX_MUL_ERRCNT_EN
   logic mis3;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         out_valid   <= 1'b0;
         prod        <= '0;
         prod_approx <= 1'b0;
`ifdef APPROX_MUL_ERRCNT_EN
         mis3        <= 1'b0;
         err_cnt     <= '0;
`endif
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (in_valid) begin
            pp1 <= pp_n;
            ap1 <= approx;
         end
         if (v1) begin
            ds2 <= ds_n;
            ap2 <= ap1;
         end
         if (v2) begin
            prod        <= ap2 ? apx_n : ex_n;
            prod_approx <= ap2;
`ifdef APPROX_MUL_ERRCNT_EN
            mis3        <= ap2 && (apx_n != ex_n);
`endif
         end
`ifdef APPROX_MUL_ERRCNT_EN
         if (out_valid && out_ready && mis3 && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
         end
`endif
      end
   end

endmodule
